// File: rtl/alu_arbiter_if.sv
// Bundle for the two ALU requesters, the shared result path and the ALU operand/result bus.
// slave: the arbiter side. master: the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int W = 32
);
  // requester side
  logic         req0;
  logic         req1;
  logic [W-1:0] x0;
  logic [W-1:0] y0;
  logic [W-1:0] x1;
  logic [W-1:0] y1;
  logic [5:0]   funct0;
  logic [5:0]   funct1;
  logic [4:0]   shamt0;
  logic [4:0]   shamt1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] res_r;
  logic         res_overflow;
  logic         res_zero;
  logic         busy;
  // ALU side
  logic [W-1:0] alu_x;
  logic [W-1:0] alu_y;
  logic [5:0]   alu_funct;
  logic [4:0]   alu_shamt;
  logic [W-1:0] alu_r;
  logic         alu_overflow;
  logic         alu_zero;

  modport slave (
    input  req0, req1, x0, y0, x1, y1, funct0, funct1, shamt0, shamt1,
    input  alu_r, alu_overflow, alu_zero,
    output ack0, ack1, res_r, res_overflow, res_zero, busy,
    output alu_x, alu_y, alu_funct, alu_shamt
  );

  modport master (
    output req0, req1, x0, y0, x1, y1, funct0, funct1, shamt0, shamt1,
    output alu_r, alu_overflow, alu_zero,
    input  ack0, ack1, res_r, res_overflow, res_zero, busy,
    input  alu_x, alu_y, alu_funct, alu_shamt
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: IDLE (grant + latch operands) -> EXEC (capture
// ALU outputs) -> RESP (one-cycle ack to the grantee) -> IDLE.
module alu_arbiter #(
  parameter int W        = 32,
  parameter bit PRIO_RST = 1'b0
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  logic         rr;      // requester favoured on the next contention
  logic         gnt;     // requester owning the operation in flight
  logic         win;
  logic [W-1:0] win_x;
  logic [W-1:0] win_y;
  logic [5:0]   win_funct;
  logic [4:0]   win_shamt;

  // Pick the winner: a lone requester wins, contention goes to the pointer.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = rr;
    end else if (bus.req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

  // Route the winner's operands toward the operand registers.
  always_comb begin
    win_x     = bus.x0;
    win_y     = bus.y0;
    win_funct = bus.funct0;
    win_shamt = bus.shamt0;
    if (win) begin
      win_x     = bus.x1;
      win_y     = bus.y1;
      win_funct = bus.funct1;
      win_shamt = bus.shamt1;
    end else begin
      win_x     = bus.x0;
      win_y     = bus.y0;
      win_funct = bus.funct0;
      win_shamt = bus.shamt0;
    end
  end

  // Arbiter FSM with all outputs registered; reset applies in every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      rr               <= PRIO_RST;
      gnt              <= 1'b0;
      bus.ack0         <= 1'b0;
      bus.ack1         <= 1'b0;
      bus.busy         <= 1'b0;
      bus.res_r        <= {W{1'b0}};
      bus.res_overflow <= 1'b0;
      bus.res_zero     <= 1'b0;
      bus.alu_x        <= {W{1'b0}};
      bus.alu_y        <= {W{1'b0}};
      bus.alu_funct    <= 6'd0;
      bus.alu_shamt    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          if (bus.req0 || bus.req1) begin
            bus.alu_x     <= win_x;
            bus.alu_y     <= win_y;
            bus.alu_funct <= win_funct;
            bus.alu_shamt <= win_shamt;
            gnt           <= win;
            rr            <= ~win;
            bus.busy      <= 1'b1;
            state         <= EXEC;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        EXEC: begin
          // Operands have been stable for a full cycle; the ALU has settled.
          bus.res_r        <= bus.alu_r;
          bus.res_overflow <= bus.alu_overflow;
          bus.res_zero     <= bus.alu_zero;
          if (gnt) begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b1;
          end else begin
            bus.ack0 <= 1'b1;
            bus.ack1 <= 1'b0;
          end
          bus.busy <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural MIPS ALU on the ALU bus.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  alu_arbiter_if #(.W(32)) bus ();

  alu_arbiter #(.W(32), .PRIO_RST(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: MIPS R-type functions, unsupported codes give 0.
  always_comb begin
    bus.alu_r        = 32'd0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_funct)
      6'h20: begin
        bus.alu_r        = bus.alu_x + bus.alu_y;
        bus.alu_overflow = (bus.alu_x[31] == bus.alu_y[31]) && (bus.alu_r[31] != bus.alu_x[31]);
      end
      6'h21: bus.alu_r = bus.alu_x + bus.alu_y;
      6'h22: begin
        bus.alu_r        = bus.alu_x - bus.alu_y;
        bus.alu_overflow = (bus.alu_x[31] != bus.alu_y[31]) && (bus.alu_r[31] != bus.alu_x[31]);
      end
      6'h23: bus.alu_r = bus.alu_x - bus.alu_y;
      6'h24: bus.alu_r = bus.alu_x & bus.alu_y;
      6'h25: bus.alu_r = bus.alu_x | bus.alu_y;
      6'h00: bus.alu_r = bus.alu_y << bus.alu_shamt;
      6'h02: bus.alu_r = bus.alu_y >> bus.alu_shamt;
      default: bus.alu_r = 32'd0;
    endcase
  end
  assign bus.alu_zero = (bus.alu_r == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant edge, ack cycle, return to IDLE; optionally drop both requests in the ack cycle.
  task automatic run_op(input string tag, input logic e_ack0, input logic e_ack1,
                        input logic [31:0] e_res, input logic e_ovf, input logic e_zero,
                        input logic drop);
    tick();
    check({tag, ".busy_exec"}, {31'd0, bus.busy}, 32'd1);
    check({tag, ".noack_exec"}, {30'd0, bus.ack1, bus.ack0}, 32'd0);
    tick();
    check({tag, ".acks"}, {30'd0, bus.ack1, bus.ack0}, {30'd0, e_ack1, e_ack0});
    check({tag, ".res"}, bus.res_r, e_res);
    check({tag, ".flags"}, {30'd0, bus.res_overflow, bus.res_zero}, {30'd0, e_ovf, e_zero});
    if (drop) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end else begin
      bus.req0 = bus.req0;
    end
    tick();
    check({tag, ".ack_cleared"}, {30'd0, bus.ack1, bus.ack0}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.x0 = 32'd0; bus.y0 = 32'd0; bus.funct0 = 6'd0; bus.shamt0 = 5'd0;
    bus.x1 = 32'd0; bus.y1 = 32'd0; bus.funct1 = 6'd0; bus.shamt1 = 5'd0;
    tick();
    tick();

    // Reset state
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check("rst.res", bus.res_r, 32'd0);
    check("rst.alu_x", bus.alu_x, 32'd0);
    check("rst.alu_fs", {21'd0, bus.alu_funct, bus.alu_shamt}, 32'd0);
    rst = 1'b1;
    tick();

    // Single add from requester 0, check operand registers after grant edge
    bus.req0 = 1'b1; bus.x0 = 32'd5; bus.y0 = 32'd7; bus.funct0 = 6'h20;
    tick();
    check("add0.alu_x", bus.alu_x, 32'd5);
    check("add0.alu_y", bus.alu_y, 32'd7);
    check("add0.alu_funct", {26'd0, bus.alu_funct}, 32'h20);
    check("add0.noack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    tick();
    check("add0.ack", {30'd0, bus.ack1, bus.ack0}, 32'd1);
    check("add0.res", bus.res_r, 32'd12);
    check("add0.flags", {30'd0, bus.res_overflow, bus.res_zero}, 32'd0);
    bus.req0 = 1'b0;
    tick();
    check("add0.idle", {29'd0, bus.busy, bus.ack1, bus.ack0}, 32'd0);

    // Fresh reset, then both held: 0,1,0,1 alternation
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req0 = 1'b1; bus.x0 = 32'd1;  bus.y0 = 32'd2;  bus.funct0 = 6'h20;
    bus.req1 = 1'b1; bus.x1 = 32'd10; bus.y1 = 32'd20; bus.funct1 = 6'h20;
    run_op("rr1", 1'b1, 1'b0, 32'd3,  1'b0, 1'b0, 1'b0);
    run_op("rr2", 1'b0, 1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
    run_op("rr3", 1'b1, 1'b0, 32'd3,  1'b0, 1'b0, 1'b0);
    run_op("rr4", 1'b0, 1'b1, 32'd30, 1'b0, 1'b0, 1'b1);

    // Signed overflow vs unsigned add from requester 1
    bus.req1 = 1'b1; bus.x1 = 32'h7FFF_FFFF; bus.y1 = 32'd1; bus.funct1 = 6'h20;
    run_op("add1", 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    bus.req1 = 1'b1; bus.funct1 = 6'h21;
    run_op("addu1", 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    // Zero flag on subtract, then a shift
    bus.req0 = 1'b1; bus.x0 = 32'h1234; bus.y0 = 32'h1234; bus.funct0 = 6'h22;
    run_op("sub0", 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    bus.req0 = 1'b1; bus.funct0 = 6'h00; bus.y0 = 32'd1; bus.shamt0 = 5'd4;
    run_op("sll0", 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b1);

    // Unsupported funct passes through; the ALU's 0 comes back
    bus.req0 = 1'b1; bus.funct0 = 6'h3F; bus.x0 = 32'd9; bus.y0 = 32'd9;
    tick();
    check("unsup.alu_funct", {26'd0, bus.alu_funct}, 32'h3F);
    tick();
    check("unsup.res", {bus.res_r[30:0], bus.ack0}, {31'd0, 1'b1});
    bus.req0 = 1'b0;
    tick();

    // Reset during EXEC: op dropped, pointer back to requester 0
    bus.req0 = 1'b1; bus.x0 = 32'd40; bus.y0 = 32'd2; bus.funct0 = 6'h20; bus.shamt0 = 5'd0;
    tick();
    check("rexec.busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    bus.req0 = 1'b0;
    tick();
    check("rexec.busy0", {31'd0, bus.busy}, 32'd0);
    check("rexec.noack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check("rexec.alu_x", bus.alu_x, 32'd0);
    check("rexec.alu_fs", {21'd0, bus.alu_funct, bus.alu_shamt}, 32'd0);
    rst = 1'b1;
    tick();
    check("rexec.idle_noack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    bus.req0 = 1'b1; bus.x0 = 32'd100; bus.y0 = 32'd1; bus.funct0 = 6'h21;
    bus.req1 = 1'b1; bus.x1 = 32'd200; bus.y1 = 32'd2; bus.funct1 = 6'h21;
    tick();
    check("rexec.grant_x", bus.alu_x, 32'd100);
    tick();
    check("rexec.ack0", {30'd0, bus.ack1, bus.ack0}, 32'd1);
    check("rexec.res", bus.res_r, 32'd101);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // One-cycle pulse on req1; operands changed after the grant edge are ignored
    bus.req1 = 1'b1; bus.x1 = 32'd100; bus.y1 = 32'd23; bus.funct1 = 6'h20;
    tick();
    bus.req1 = 1'b0; bus.x1 = 32'd999; bus.y1 = 32'd999; bus.funct1 = 6'h22;
    tick();
    check("pulse1.ack", {30'd0, bus.ack1, bus.ack0}, 32'd2);
    check("pulse1.res", bus.res_r, 32'd123);
    tick();
    check("pulse1.idle", {29'd0, bus.busy, bus.ack1, bus.ack0}, 32'd0);
    tick();
    check("pulse1.noregrant", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
